// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants for the 8x12b FIFO controller
package fifo_pkg;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int CNT_W  = 4;

   localparam logic [CNT_W-1:0] TH_AF_DEF = 4'd6;
   localparam logic [CNT_W-1:0] TH_AE_DEF = 4'd2;

   localparam logic [3:0] ST_RESET  = 4'd0;
   localparam logic [3:0] ST_INIT   = 4'd1;
   localparam logic [3:0] ST_IDLE   = 4'd2;
   localparam logic [3:0] ST_ACTIVE = 4'd3;
   localparam logic [3:0] ST_ERROR  = 4'd4;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// rtl/fifo_wrap_ptr.sv - wrapping RAM pointer with sync clear and enable
module fifo_wrap_ptr #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset_L,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] ptr
);

   // Wrap at DEPTH relies on DEPTH being exactly 2**W.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= ptr + W'(1);
      end
   end

endmodule

// File: rtl/fifo_ctrl_8x12b.sv
// rtl/fifo_ctrl_8x12b.sv - FSM, occupancy and flags driving the 8x12b FIFO RAM
module fifo_ctrl_8x12b
   import fifo_pkg::*;
(
   input  logic              clk,
   input  logic              reset_L,
   input  logic              init,
   input  logic [CNT_W-1:0]  th_af,
   input  logic [CNT_W-1:0]  th_ae,
   input  logic              push,
   input  logic              pop,
   output logic              we_a,
   output logic              re_a,
   output logic [ADDR_W-1:0] addr_wa,
   output logic [ADDR_W-1:0] addr_ra,
   output logic [3:0]        state,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              error,
   output logic              rd_valid
);

   logic [3:0]       state_d;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] th_af_q, th_ae_q, th_af_d, th_ae_d;
   logic             running, go_init, ptr_clr;
   logic             wr_ok, rd_ok, overflow, underflow;
   logic             error_d;

   // init overrides every other event, so it also blocks RAM access.
   assign running   = ((state == ST_IDLE) || (state == ST_ACTIVE)) && !init;
   assign go_init   = init && (state != ST_RESET);
   assign ptr_clr   = go_init || (state == ST_INIT);

   assign wr_ok     = running && push && (!full || pop);
   assign rd_ok     = running && pop && !empty;
   assign overflow  = running && push && full && !pop;
   assign underflow = running && pop && empty;

   assign we_a = wr_ok;
   assign re_a = rd_ok;

   fifo_wrap_ptr #(.W(ADDR_W)) u_wr_ptr (
      .clk     (clk),
      .reset_L (reset_L),
      .clr     (ptr_clr),
      .en      (wr_ok),
      .ptr     (addr_wa)
   );

   fifo_wrap_ptr #(.W(ADDR_W)) u_rd_ptr (
      .clk     (clk),
      .reset_L (reset_L),
      .clr     (ptr_clr),
      .en      (rd_ok),
      .ptr     (addr_ra)
   );

   always_comb begin
      count_d = count;
      if (ptr_clr) begin
         count_d = '0;
      end else if (wr_ok && !rd_ok) begin
         count_d = count + CNT_W'(1);
      end else if (!wr_ok && rd_ok) begin
         count_d = count - CNT_W'(1);
      end
   end

   always_comb begin
      th_af_d = th_af_q;
      th_ae_d = th_ae_q;
      if (state == ST_INIT) begin
         th_af_d = th_af;
         th_ae_d = th_ae;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         ST_RESET:  state_d = ST_INIT;
         ST_INIT:   state_d = init ? ST_INIT : ST_IDLE;
         ST_IDLE,
         ST_ACTIVE: begin
            if (init) begin
               state_d = ST_INIT;
            end else if (overflow || underflow) begin
               state_d = ST_ERROR;
            end else if (count_d == '0) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ACTIVE;
            end
         end
         ST_ERROR:  state_d = init ? ST_INIT : ST_ERROR;
         default:   state_d = ST_INIT;
      endcase
   end

   always_comb begin
      error_d = error;
      if (go_init) begin
         error_d = 1'b0;
      end else if (overflow || underflow) begin
         error_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state        <= ST_RESET;
         count        <= '0;
         th_af_q      <= TH_AF_DEF;
         th_ae_q      <= TH_AE_DEF;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         error        <= 1'b0;
         rd_valid     <= 1'b0;
      end else begin
         state        <= state_d;
         count        <= count_d;
         th_af_q      <= th_af_d;
         th_ae_q      <= th_ae_d;
         full         <= (count_d == CNT_W'(DEPTH));
         empty        <= (count_d == '0);
         almost_full  <= (count_d >= th_af_d);
         almost_empty <= (count_d <= th_ae_d);
         error        <= error_d;
         rd_valid     <= rd_ok;
      end
   end

endmodule

// File: tb/tb_fifo_ctrl_8x12b.sv
// tb/tb_fifo_ctrl_8x12b.sv - directed vector bench for fifo_ctrl_8x12b
module tb_fifo_ctrl_8x12b;

   logic        clk;
   logic        reset_L;
   logic        init;
   logic [3:0]  th_af, th_ae;
   logic        push, pop;
   logic [11:0] data;
   logic        we_a, re_a;
   logic [2:0]  addr_wa, addr_ra;
   logic [3:0]  state, count;
   logic        full, empty, almost_full, almost_empty, error, rd_valid;

   logic [11:0] mem [8];
   logic [11:0] q_a;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        push, pop;
      logic [11:0] data;
      logic        we, re;
      logic [3:0]  cnt;
      logic [3:0]  flg;
      logic [3:0]  st;
      logic        err, rdv, chkq;
      logic [11:0] q;
      logic [2:0]  wa, ra;
   } vec_t;

   vec_t tv[$];

   fifo_ctrl_8x12b dut (
      .clk          (clk),
      .reset_L      (reset_L),
      .init         (init),
      .th_af        (th_af),
      .th_ae        (th_ae),
      .push         (push),
      .pop          (pop),
      .we_a         (we_a),
      .re_a         (re_a),
      .addr_wa      (addr_wa),
      .addr_ra      (addr_ra),
      .state        (state),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .error        (error),
      .rd_valid     (rd_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural dual-port RAM with registered read, as the controller expects.
   always @(posedge clk) begin
      if (we_a) mem[addr_wa] <= data;
      if (re_a) q_a <= mem[addr_ra];
   end

   function automatic vec_t mk(input logic p, input logic po, input logic [11:0] d,
                               input logic we, input logic re, input logic [3:0] c,
                               input logic [3:0] f, input logic [3:0] s, input logic e,
                               input logic rv, input logic cq, input logic [11:0] q,
                               input logic [2:0] wa, input logic [2:0] ra);
      vec_t v;
      v.push = p;  v.pop = po; v.data = d; v.we = we; v.re = re; v.cnt = c;
      v.flg = f;   v.st = s;   v.err = e;  v.rdv = rv; v.chkq = cq; v.q = q;
      v.wa = wa;   v.ra = ra;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic p, input logic po, input logic [11:0] d);
      push = p;
      pop  = po;
      data = d;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_vec(input int i, input vec_t v);
      string tag;
      tag = $sformatf("v%0d", i);
      drive(v.push, v.pop, v.data);
      chk({tag, ".we_a"}, we_a, v.we);
      chk({tag, ".re_a"}, re_a, v.re);
      tick();
      chk({tag, ".count"}, count, v.cnt);
      chk({tag, ".flags"}, {full, empty, almost_full, almost_empty}, v.flg);
      chk({tag, ".state"}, state, v.st);
      chk({tag, ".error"}, error, v.err);
      chk({tag, ".rd_valid"}, rd_valid, v.rdv);
      if (v.chkq) chk({tag, ".q_a"}, q_a, v.q);
      chk({tag, ".addr_wa"}, addr_wa, v.wa);
      chk({tag, ".addr_ra"}, addr_ra, v.ra);
      @(negedge clk);
   endtask

   task automatic do_init(input string tag);
      init  = 1'b1;
      th_af = 4'd5;
      th_ae = 4'd1;
      drive(1'b1, 1'b0, 12'h0FF);
      chk({tag, ".init_blocks_we"}, we_a, 0);
      tick();
      chk({tag, ".init_state"}, state, 1);
      chk({tag, ".init_count"}, count, 0);
      chk({tag, ".init_error"}, error, 0);
      @(negedge clk);
      init = 1'b0;
      drive(1'b0, 1'b0, 12'h000);
      tick();
      chk({tag, ".idle_state"}, state, 2);
      chk({tag, ".idle_ptrs"}, {addr_wa, addr_ra}, 0);
      chk({tag, ".idle_flags"}, {full, empty, almost_full, almost_empty}, 4'b0101);
      @(negedge clk);
   endtask

   initial begin
      // first fill with thresholds af=5, ae=1; flags are {full,empty,af,ae}
      tv.push_back(mk(1,0,12'h001, 1,0, 4'd1, 4'b0001, 4'd3, 0,0,0,12'h000, 3'd1,3'd0));
      tv.push_back(mk(1,0,12'h002, 1,0, 4'd2, 4'b0000, 4'd3, 0,0,0,12'h000, 3'd2,3'd0));
      tv.push_back(mk(1,0,12'h003, 1,0, 4'd3, 4'b0000, 4'd3, 0,0,0,12'h000, 3'd3,3'd0));
      tv.push_back(mk(1,0,12'h004, 1,0, 4'd4, 4'b0000, 4'd3, 0,0,0,12'h000, 3'd4,3'd0));
      tv.push_back(mk(1,0,12'h005, 1,0, 4'd5, 4'b0010, 4'd3, 0,0,0,12'h000, 3'd5,3'd0));
      tv.push_back(mk(1,0,12'h006, 1,0, 4'd6, 4'b0010, 4'd3, 0,0,0,12'h000, 3'd6,3'd0));
      tv.push_back(mk(1,0,12'h007, 1,0, 4'd7, 4'b0010, 4'd3, 0,0,0,12'h000, 3'd7,3'd0));
      tv.push_back(mk(1,0,12'h008, 1,0, 4'd8, 4'b1010, 4'd3, 0,0,0,12'h000, 3'd0,3'd0));
      // drain
      tv.push_back(mk(0,1,12'h000, 0,1, 4'd7, 4'b0010, 4'd3, 0,1,1,12'h001, 3'd0,3'd1));
      tv.push_back(mk(0,1,12'h000, 0,1, 4'd6, 4'b0010, 4'd3, 0,1,1,12'h002, 3'd0,3'd2));
      tv.push_back(mk(0,1,12'h000, 0,1, 4'd5, 4'b0010, 4'd3, 0,1,1,12'h003, 3'd0,3'd3));
      tv.push_back(mk(0,1,12'h000, 0,1, 4'd4, 4'b0000, 4'd3, 0,1,1,12'h004, 3'd0,3'd4));
      tv.push_back(mk(0,1,12'h000, 0,1, 4'd3, 4'b0000, 4'd3, 0,1,1,12'h005, 3'd0,3'd5));
      tv.push_back(mk(0,1,12'h000, 0,1, 4'd2, 4'b0000, 4'd3, 0,1,1,12'h006, 3'd0,3'd6));
      tv.push_back(mk(0,1,12'h000, 0,1, 4'd1, 4'b0001, 4'd3, 0,1,1,12'h007, 3'd0,3'd7));
      tv.push_back(mk(0,1,12'h000, 0,1, 4'd0, 4'b0101, 4'd2, 0,1,1,12'h008, 3'd0,3'd0));
      tv.push_back(mk(0,0,12'h000, 0,0, 4'd0, 4'b0101, 4'd2, 0,0,0,12'h000, 3'd0,3'd0));
      // second fill
      tv.push_back(mk(1,0,12'h011, 1,0, 4'd1, 4'b0001, 4'd3, 0,0,0,12'h000, 3'd1,3'd0));
      tv.push_back(mk(1,0,12'h012, 1,0, 4'd2, 4'b0000, 4'd3, 0,0,0,12'h000, 3'd2,3'd0));
      tv.push_back(mk(1,0,12'h013, 1,0, 4'd3, 4'b0000, 4'd3, 0,0,0,12'h000, 3'd3,3'd0));
      tv.push_back(mk(1,0,12'h014, 1,0, 4'd4, 4'b0000, 4'd3, 0,0,0,12'h000, 3'd4,3'd0));
      tv.push_back(mk(1,0,12'h015, 1,0, 4'd5, 4'b0010, 4'd3, 0,0,0,12'h000, 3'd5,3'd0));
      tv.push_back(mk(1,0,12'h016, 1,0, 4'd6, 4'b0010, 4'd3, 0,0,0,12'h000, 3'd6,3'd0));
      tv.push_back(mk(1,0,12'h017, 1,0, 4'd7, 4'b0010, 4'd3, 0,0,0,12'h000, 3'd7,3'd0));
      tv.push_back(mk(1,0,12'h018, 1,0, 4'd8, 4'b1010, 4'd3, 0,0,0,12'h000, 3'd0,3'd0));
      // push+pop while full, then overflow and frozen ERROR
      tv.push_back(mk(1,1,12'hABC, 1,1, 4'd8, 4'b1010, 4'd3, 0,1,0,12'h000, 3'd1,3'd1));
      tv.push_back(mk(1,0,12'h0DD, 0,0, 4'd8, 4'b1010, 4'd4, 1,0,0,12'h000, 3'd1,3'd1));
      tv.push_back(mk(1,1,12'h0EE, 0,0, 4'd8, 4'b1010, 4'd4, 1,0,0,12'h000, 3'd1,3'd1));
      tv.push_back(mk(0,1,12'h000, 0,0, 4'd8, 4'b1010, 4'd4, 1,0,0,12'h000, 3'd1,3'd1));

      reset_L = 1'b0;
      init    = 1'b0;
      th_af   = 4'd0;
      th_ae   = 4'd0;
      push    = 1'b1;
      pop     = 1'b1;
      data    = 12'h000;

      repeat (2) @(posedge clk);
      #1;
      chk("rst.state", state, 0);
      chk("rst.count", count, 0);
      chk("rst.flags", {full, empty, almost_full, almost_empty}, 4'b0101);
      chk("rst.err_rdv", {error, rd_valid}, 0);
      chk("rst.we_re", {we_a, re_a}, 0);

      @(negedge clk);
      reset_L = 1'b1;
      init    = 1'b1;
      th_af   = 4'd5;
      th_ae   = 4'd1;
      drive(1'b0, 1'b0, 12'h000);
      tick();
      chk("boot.state_init", state, 1);
      @(negedge clk);
      init = 1'b0;
      tick();
      chk("boot.state_idle", state, 2);
      chk("boot.flags", {full, empty, almost_full, almost_empty}, 4'b0101);
      @(negedge clk);

      foreach (tv[i]) apply_vec(i, tv[i]);

      do_init("after_ovf");

      // underflow: pop on empty while a push is accepted
      drive(1'b1, 1'b1, 12'h123);
      chk("udf.we_a", we_a, 1);
      chk("udf.re_a", re_a, 0);
      tick();
      chk("udf.count", count, 1);
      chk("udf.error", error, 1);
      chk("udf.state", state, 4);
      chk("udf.flags", {full, empty, almost_full, almost_empty}, 4'b0001);
      chk("udf.mem0", mem[0], 12'h123);
      @(negedge clk);

      do_init("after_udf");

      // three entries, then drop reset between edges
      for (int k = 1; k <= 3; k++) begin
         drive(1'b1, 1'b0, 12'h0A0 + 12'(k));
         tick();
         chk($sformatf("ar.fill%0d", k), count, k);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 12'h000);
      @(posedge clk);
      #2;
      reset_L = 1'b0;
      #1;
      chk("ar.state", state, 0);
      chk("ar.count", count, 0);
      chk("ar.flags", {full, empty, almost_full, almost_empty}, 4'b0101);
      chk("ar.ptrs", {addr_wa, addr_ra}, 0);
      drive(1'b1, 1'b1, 12'h000);
      chk("ar.we_re", {we_a, re_a}, 0);
      @(negedge clk);
      reset_L = 1'b1;
      drive(1'b0, 1'b0, 12'h000);
      do_init("after_ar");

      drive(1'b1, 1'b0, 12'h0AA);
      chk("ar2.addr_wa", addr_wa, 0);
      tick();
      chk("ar2.count", count, 1);
      @(negedge clk);
      drive(1'b0, 1'b1, 12'h000);
      chk("ar2.addr_ra", addr_ra, 0);
      chk("ar2.re_a", re_a, 1);
      tick();
      chk("ar2.rd_valid", rd_valid, 1);
      chk("ar2.q_a", q_a, 12'h0AA);
      chk("ar2.state", state, 2);
      @(negedge clk);
      drive(1'b0, 1'b0, 12'h000);
      tick();
      chk("ar2.rd_valid_drop", rd_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl_8x12b.md
# fifo_ctrl_8x12b

Control and sequencing block for the 8-entry × 12-bit FIFO. It drives the dual-port RAM's write/read enables and addresses and its 4-bit `state` input. It tracks occupancy, raises full/empty/almost-full/almost-empty flags against thresholds programmable at init, and traps overflow and underflow in a sticky error state. It sits between the upstream producer/downstream consumer handshake and the RAM instance.

## Interface
- `DEPTH`, 8, number of RAM entries; power of two.
- `ADDR_W`, 3, pointer width, log2(`DEPTH`).
- `CNT_W`, 4, occupancy width, range 0..`DEPTH`.
- `TH_AF_DEF`, 6, almost-full threshold used until first init.
- `TH_AE_DEF`, 2, almost-empty threshold used until first init.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `init`  in  1  level; enter INIT, flush pointers, sample thresholds.
- `th_af`  in  CNT_W  almost-full threshold, sampled while in INIT.
- `th_ae`  in  CNT_W  almost-empty threshold, sampled while in INIT.
- `push`  in  1  producer write request; data goes directly to RAM `data_a`.
- `pop`  in  1  consumer read request.
- `we_a`  out  1  RAM write enable.
- `re_a`  out  1  RAM read enable.
- `addr_wa`  out  ADDR_W  RAM write address; equals `wr_ptr`.
- `addr_ra`  out  ADDR_W  RAM read address; equals `rd_ptr`.
- `state`  out  4  FSM state, also fed to RAM.
- `count`  out  CNT_W  current occupancy.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1 each  registered flags.
- `error`  out  1  sticky overflow/underflow indicator.
- `rd_valid`  out  1  RAM `q_a` holds popped data this cycle.

## Operation
- **State encodings:** RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- **Reset values** (while `reset_L`=0):
  - state=RESET; `wr_ptr`=`rd_ptr`=0; `count`=0.
  - `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0.
  - `error`=0, `rd_valid`=0, `we_a`=`re_a`=0.
  - Thresholds = defaults.
- **Transitions:**
  - RESET→INIT on the first edge after release.
  - INIT→IDLE on an edge with `init`=0.
  - IDLE→ACTIVE on an accepted push.
  - ACTIVE→IDLE when next `count`=0.
  - Any non-RESET state→INIT when `init`=1; this takes priority over all other events.
  - IDLE or ACTIVE→ERROR on overflow or underflow.
  - ERROR persists until `init`.
- **INIT:**
  - Pointers and count are cleared every cycle.
  - `th_af` and `th_ae` are registered every cycle.
  - `we_a` and `re_a` are held 0.
- **Accept rules** (IDLE or ACTIVE only):
  - `wr_ok` = push & (!full | pop).
  - `rd_ok` = pop & !empty.
  - `we_a` = `wr_ok`; `re_a` = `rd_ok`. Both are combinational, so the RAM acts on the same edge.
- **Error conditions:**
  - Overflow: push & full & !pop.
  - Underflow: pop & empty, even if push is also accepted that cycle.
  - On error: the legal half of the cycle still completes, `error` is set, and state→ERROR.
  - In ERROR: `we_a`=`re_a`=0; pointers and count are frozen.
- **Arithmetic:**
  - Pointers increment modulo `DEPTH`; wrap 7→0 is natural ADDR_W overflow.
  - `count` += `wr_ok` − `rd_ok`, never exceeding `DEPTH`.
  - Simultaneous accepted push and pop: both pointers advance, count unchanged. This is legal when full. When empty it is push plus underflow.
- **Flags** (registered, computed from next count):
  - `full` = (count==DEPTH); `empty` = (count==0).
  - `almost_full` = (count ≥ `th_af`); `almost_empty` = (count ≤ `th_ae`).
  - A threshold of 0 or above `DEPTH` is accepted and simply saturates the flag.

## Timing
- **Write:** 0-cycle control latency; the entry is stored at the edge where `push` is accepted.
- **Read:** `re_a` at edge N; RAM `q_a` is valid after edge N. `rd_valid`=1 during cycle N+1 only, i.e. a registered copy of `re_a`.
- **Flag/count latency:** `count`, flags and `state` update at the same edge as the RAM operation and are visible the following cycle.
- **Async reset mid-operation:** all outputs go to reset values immediately, without waiting for `clk`. RAM contents are not cleared.
- **`init` mid-operation:** in-flight `rd_valid` still asserts for the preceding pop. Pointers are 0 on the next cycle.

## Structure
- Shared package `fifo_pkg`:
  - State encodings (4-bit).
  - `DEPTH`, `ADDR_W`, `CNT_W`.
  - Default thresholds.
- Sub-module `fifo_wrap_ptr`: ADDR_W counter with async active-low reset, synchronous clear, and enable. Instantiated twice, for `wr_ptr` and `rd_ptr`.
- The FSM, count and flags live in the top level.

## Test plan
- **Reset/init:**
  - Hold `reset_L`=0 → state=0, `empty`=1, `count`=0.
  - Release, `init`=1 with `th_af`=5, `th_ae`=1, then `init`=0 → state 1 then 2.
- **Fill:**
  - 8 pushes of 0x001..0x008 → `almost_full` rises after push 5, `full` after push 8, `addr_wa` wraps to 0, state=3.
  - Then 8 pops → `q_a` returns 0x001..0x008 with `rd_valid` one cycle after each `re_a`; `empty`=1, state=2.
- **Full with push+pop:** at count=8, push 0xABC and pop simultaneously → `count` stays 8, `error`=0, both pointers advance.
- **Overflow:** at count=8, push alone → `we_a`=0, `error`=1, state=4. Further pushes/pops have no effect until `init`, after which `count`=0.
- **Underflow:** at count=0, pop with push 0x123 → entry written, `count`=1, `error`=1, state=4.
- **Async reset mid-stream:** drop `reset_L` between clock edges at count=3 → outputs reset immediately. Subsequent init and push/pop work from address 0.
